// File: rtl/fetch_decode_fsm_pkg.sv
// Shared definitions for the fetch/decode sequencer: opcode values, instruction field
// positions and the sequencer state encoding.
package fetch_decode_fsm_pkg;

  localparam logic [3:0] OP_MOVI = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Number of opcodes that hand off to an execution FSM.
  localparam int unsigned NUM_EXEC_OPS = 32'(OP_SUB) + 1;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned P1_MSB     = 11;
  localparam int unsigned P1_LSB     = 6;
  localparam int unsigned P2_MSB     = 5;
  localparam int unsigned P2_LSB     = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

  // Opcode lane for an execution opcode (0 when it is not one of the four).
  function automatic logic [3:0] exec_lane(input logic [3:0] op);
    logic [3:0] lane;
    lane = 4'b0000;
    case (op)
      OP_MOVI: lane = 4'b0001;
      OP_MOV:  lane = 4'b0010;
      OP_ADD:  lane = 4'b0100;
      OP_SUB:  lane = 4'b1000;
      default: lane = 4'b0000;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode sequencer: reads a word at pc, decodes it, drives the one-hot start
// handshake to the per-opcode execution FSMs and advances pc once the selected FSM reports done.
module fetch_decode_fsm
  import fetch_decode_fsm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned NUM_OPS = NUM_EXEC_OPS,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  pc,
  input  logic [15:0]        mem_data,
  input  logic               mem_valid,
  output logic [3:0]         opcode,
  output logic [5:0]         parameter1,
  output logic [5:0]         parameter2,
  output logic               donefetch,
  output logic [NUM_OPS-1:0] start,
  input  logic [NUM_OPS-1:0] done,
  output logic               halted,
  output logic               illegal,
  output logic               timeout_err
);

  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

  state_e             state_q;
  logic [WdogW-1:0]   wdog_q;
  logic               lane_done;
  logic               op_legal;
  logic [NUM_OPS-1:0] op_lane;

  // start is one-hot on the active lane during EXEC, so masking done with it selects that lane.
  assign lane_done = |(done & start);
  assign op_legal  = 32'(opcode) < NUM_OPS;
  assign op_lane   = NUM_OPS'(1) << opcode;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc          <= '0;
      mem_rd      <= 1'b0;
      opcode      <= '0;
      parameter1  <= '0;
      parameter2  <= '0;
      donefetch   <= 1'b0;
      start       <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      timeout_err <= 1'b0;
      wdog_q      <= '0;
    end else begin
      donefetch <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StFetch;
            mem_rd  <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_valid) begin
            opcode     <= mem_data[OPCODE_MSB:OPCODE_LSB];
            parameter1 <= mem_data[P1_MSB:P1_LSB];
            parameter2 <= mem_data[P2_MSB:P2_LSB];
            donefetch  <= 1'b1;
            mem_rd     <= 1'b0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          if (op_legal) begin
            start   <= op_lane;
            wdog_q  <= '0;
            state_q <= StExec;
          end else if (opcode == OP_HALT) begin
            halted  <= 1'b1;
            state_q <= StHalt;
          end else begin
            illegal <= 1'b1;
            pc      <= pc + ADDR_W'(1);
            mem_rd  <= run;
            state_q <= run ? StFetch : StIdle;
          end
        end
        StExec: begin
          // done on the active lane wins over a watchdog expiry in the same cycle.
          if (lane_done || (wdog_q == WdogLast)) begin
            start  <= '0;
            pc     <= pc + ADDR_W'(1);
            wdog_q <= '0;
            if (lane_done) begin
              mem_rd  <= run;
              state_q <= run ? StFetch : StIdle;
            end else begin
              timeout_err <= 1'b1;
              state_q     <= StIdle;
            end
          end else begin
            wdog_q <= wdog_q + WdogW'(1);
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Bench for fetch_decode_fsm: memory and execution-FSM responders, a decode scoreboard and
// directed plus randomized program runs.
module tb_fetch_decode_fsm;

  localparam int unsigned AW   = 8;
  localparam int unsigned NOPS = 4;
  localparam int unsigned TMO  = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            mem_rd;
  logic [AW-1:0]   pc;
  logic [15:0]     mem_data;
  logic            mem_valid;
  logic [3:0]      opcode;
  logic [5:0]      parameter1;
  logic [5:0]      parameter2;
  logic            donefetch;
  logic [NOPS-1:0] start;
  logic [NOPS-1:0] done;
  logic [NOPS-1:0] done_auto;
  logic [NOPS-1:0] done_man;
  logic            halted;
  logic            illegal;
  logic            timeout_err;

  assign done = done_auto | done_man;

  always #5 clk = ~clk;

  fetch_decode_fsm #(
    .ADDR_W (AW),
    .NUM_OPS(NOPS),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem_rd     (mem_rd),
    .pc         (pc),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .opcode     (opcode),
    .parameter1 (parameter1),
    .parameter2 (parameter2),
    .donefetch  (donefetch),
    .start      (start),
    .done       (done),
    .halted     (halted),
    .illegal    (illegal),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  lane;
    logic        ill;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[256];

  int n_cmp = 0;
  int n_fail = 0;
  int n_decoded = 0;

  // Bench knobs written by the main sequence.
  logic exec_en;
  logic force_tmo;
  logic tmo_rand;

  // Reference model state.
  logic [AW-1:0] model_pc;
  logic          model_ill;
  logic          model_tmo;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program memory: answers a read after 0..2 extra cycles and records what decode must show.
  logic [15:0] m_word;
  int          m_wait;
  int          m_lat;
  exp_t        m_e;
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    model_pc  = '0;
    model_ill = 1'b0;
    m_wait    = 0;
    m_lat     = 0;
    forever begin
      tick();
      if (!rst) begin
        mem_valid = 1'b0;
        model_pc  = '0;
        model_ill = 1'b0;
        m_wait    = 0;
      end else if (mem_valid) begin
        mem_valid = 1'b0;
      end else if (mem_rd) begin
        if (m_wait < m_lat) begin
          m_wait++;
        end else begin
          check("fetch_pc", 32'(pc), 32'(model_pc));
          m_word    = mem[pc];
          mem_data  = m_word;
          mem_valid = 1'b1;
          m_e.word  = m_word;
          m_e.lane  = (m_word[15:12] < NOPS) ? 4'(1 << m_word[15:12]) : 4'b0000;
          m_e.ill   = model_ill;
          m_e.tmo   = model_tmo;
          exp_q.push_back(m_e);
          if (m_word[15:12] >= NOPS && m_word[15:12] != 4'hF) model_ill = 1'b1;
          if (m_word[15:12] != 4'hF) model_pc = model_pc + 1'b1;
          m_wait = 0;
          m_lat  = $urandom_range(0, 2);
        end
      end
    end
  end

  // Execution FSMs: answer the active lane after a random delay (with noise on other lanes),
  // or withhold done to force a watchdog abort.
  logic [NOPS-1:0] x_lane;
  int              x_n;
  int              x_d;
  initial begin
    done_auto = '0;
    model_tmo = 1'b0;
    forever begin
      tick();
      done_auto = '0;
      if (!rst) begin
        model_tmo = 1'b0;
      end else if (exec_en && start != '0) begin
        x_lane = start;
        if (force_tmo || (tmo_rand && $urandom_range(0, 31) == 0)) begin
          model_tmo = 1'b1;
          x_n = 0;
          while (start != '0 && x_n < int'(TMO) + 8) begin
            done_auto = ~x_lane & 4'($urandom);
            tick();
            x_n++;
          end
          done_auto = '0;
          check("timeout_len", 32'(x_n), TMO);
          check("timeout_flag", 32'(timeout_err), 1);
        end else begin
          x_d = $urandom_range(0, 4);
          for (int i = 0; i < x_d; i++) begin
            done_auto = ~x_lane & 4'($urandom);
            tick();
            check("start_hold", 32'(start), 32'(x_lane));
          end
          done_auto = x_lane | 4'($urandom);
          tick();
          done_auto = '0;
          check("start_release", 32'(start), 0);
        end
      end
    end
  end

  // Scoreboard monitor: every donefetch pulse pops one expected decode.
  exp_t            mon_e;
  logic            mon_chk;
  logic [NOPS-1:0] mon_lane;
  initial begin
    mon_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        mon_chk = 1'b0;
      end else begin
        if (mon_chk) begin
          check("start_after_decode", 32'(start), 32'(mon_lane));
          check("donefetch_pulse", 32'(donefetch), 0);
          mon_chk = 1'b0;
        end
        if (donefetch) begin
          n_decoded++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL decode_unexpected: got donefetch at pc %0h, required none", pc);
          end else begin
            mon_e = exp_q.pop_front();
            check("decode_fields", 32'({opcode, parameter1, parameter2}), 32'(mon_e.word));
            check("decode_flags", 32'({illegal, timeout_err, halted}),
                  32'({mon_e.ill, mon_e.tmo, 1'b0}));
            mon_lane = mon_e.lane;
            mon_chk  = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_reset(input string name);
    rst = 1'b0;
    tick();
    tick();
    check({name, "_ctrl"}, 32'({start, pc, mem_rd, donefetch, halted, illegal, timeout_err}), 0);
    check({name, "_fields"}, 32'({opcode, parameter1, parameter2}), 0);
    run = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_start(input string name, input logic [NOPS-1:0] lane);
    int n = 0;
    while (start == '0 && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(start), 32'(lane));
  endtask

  task automatic wait_halt(input int lim);
    int n = 0;
    while (!halted && n < lim) begin
      tick();
      n++;
    end
  endtask

  int bad;
  int cyc;
  int base;
  logic [3:0] r_op;
  initial begin
    rst = 1'b0;
    run = 1'b0;
    done_man = '0;
    exec_en = 1'b0;
    force_tmo = 1'b0;
    tmo_rand = 1'b0;
    foreach (mem[i]) mem[i] = 16'h0000;

    do_reset("reset_init");

    // movi, wrong-lane done, then illegal and halt.
    mem[0] = 16'h0003;
    mem[1] = 16'h9000;
    mem[2] = 16'hF000;
    run = 1'b1;
    wait_start("movi_start", 4'b0001);
    check("movi_fields", 32'({opcode, parameter1, parameter2}), 32'h0003);
    done_man = 4'b0100;
    tick();
    done_man = '0;
    check("wrong_lane_ignored", 32'({start, pc}), 32'({4'b0001, 8'd0}));
    done_man = 4'b0001;
    tick();
    done_man = '0;
    check("done_advance", 32'({start, pc}), 32'({4'b0000, 8'd1}));
    wait_halt(60);
    check("halt_flags", 32'({halted, illegal, timeout_err, pc}), 32'({3'b110, 8'd2}));
    bad = 0;
    repeat (20) begin
      tick();
      if (mem_rd || start != '0 || !halted) bad++;
    end
    check("halt_quiet", 32'(bad), 0);

    // Reset while an execution FSM is being started.
    do_reset("reset_pre");
    mem[0] = 16'h1042;
    run = 1'b1;
    wait_start("mov_start", 4'b0010);
    repeat (3) tick();
    do_reset("reset_mid_exec");
    bad = 0;
    repeat (5) begin
      tick();
      if (mem_rd || start != '0) bad++;
    end
    check("idle_after_reset", 32'(bad), 0);

    // Watchdog abort, then halt on the following word.
    mem[0] = 16'h2105;
    mem[1] = 16'hF000;
    exec_en = 1'b1;
    force_tmo = 1'b1;
    run = 1'b1;
    wait_halt(300);
    force_tmo = 1'b0;
    check("timeout_result", 32'({halted, illegal, timeout_err, pc}), 32'({3'b101, 8'd1}));

    // Random program long enough to wrap pc, with run toggling and occasional aborts.
    do_reset("reset_rand");
    for (int i = 0; i < 256; i++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 14)) : 4'($urandom_range(0, 3));
      mem[i] = {r_op, 12'($urandom)};
    end
    tmo_rand = 1'b1;
    base = n_decoded;
    cyc = 0;
    run = 1'b1;
    while (n_decoded < base + 280 && cyc < 40000) begin
      tick();
      run = ($urandom_range(0, 15) != 0);
      cyc++;
    end
    check("rand_progress", 32'(n_decoded >= base + 280), 1);

    // Drop run mid-execution: the instruction finishes and the sequencer stays idle.
    run = 1'b1;
    cyc = 0;
    while (start == '0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("final_exec_seen", 32'(start != '0), 1);
    run = 1'b0;
    cyc = 0;
    while (start != '0 && cyc < 100) begin
      tick();
      cyc++;
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (mem_rd || start != '0) bad++;
    end
    check("run_drop_idle", 32'(bad), 0);
    check("final_pc", 32'(pc), 32'(model_pc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
